// File: rtl/arbitro_multiplicador.sv
// Round-robin arbiter sharing one start/busy shift-add multiplier between two requesters.
// ack one cycle after the grant edge, done one cycle after busy is seen low; requests wait in IDLE while the multiplier is busy.
module arbitro_multiplicador #(
   parameter int WIDTH        = 8,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0,
   input  logic [WIDTH-1:0]     p0,
   input  logic [WIDTH-1:0]     q0,
   output logic                 ack0,
   output logic                 done0,
   output logic [2*WIDTH-1:0]   m0,
   input  logic                 req1,
   input  logic [WIDTH-1:0]     p1,
   input  logic [WIDTH-1:0]     q1,
   output logic                 ack1,
   output logic                 done1,
   output logic [2*WIDTH-1:0]   m1,
   output logic                 mul_start,
   output logic [WIDTH-1:0]     mul_p,
   output logic [WIDTH-1:0]     mul_q,
   input  logic                 mul_busy,
   input  logic [2*WIDTH-1:0]   mul_m,
   output logic                 owner,
   output logic                 err
);

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_DONE} state_t;

   localparam logic [3:0] TMO = 4'(BUSY_TIMEOUT);

   state_t               r_state;
   logic                 r_last_grant;
   logic                 r_owner;
   logic [3:0]           r_cnt;
   logic                 r_mul_start;
   logic [WIDTH-1:0]     r_mul_p;
   logic [WIDTH-1:0]     r_mul_q;
   logic                 r_ack0;
   logic                 r_ack1;
   logic                 r_done0;
   logic                 r_done1;
   logic                 r_err;
   logic [2*WIDTH-1:0]   r_m0;
   logic [2*WIDTH-1:0]   r_m1;

   logic                 w_grant;
   logic                 w_win;
   logic [3:0]           w_cnt_nxt;
   logic                 w_timeout;
   logic                 w_finish;
   logic [2*WIDTH-1:0]   w_result;

   // On a tie the requester that did not win last time is served.
   assign w_grant   = (req0 | req1) & ~mul_busy;
   assign w_win     = req1 & (~req0 | ~r_last_grant);
   assign w_cnt_nxt = r_cnt + 4'd1;
   assign w_timeout = (r_state == S_WAIT_BUSY) && !mul_busy && (w_cnt_nxt == TMO);
   assign w_finish  = w_timeout || ((r_state == S_RUN) && !mul_busy);
   assign w_result  = w_timeout ? '0 : mul_m;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_cnt        <= '0;
         r_mul_start  <= 1'b0;
         r_mul_p      <= '0;
         r_mul_q      <= '0;
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_err        <= 1'b0;
         r_m0         <= '0;
         r_m1         <= '0;
      end else begin
         r_mul_start <= 1'b0;
         r_ack0      <= 1'b0;
         r_ack1      <= 1'b0;
         r_done0     <= 1'b0;
         r_done1     <= 1'b0;
         r_err       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_owner     <= w_win;
                  r_mul_p     <= w_win ? p1 : p0;
                  r_mul_q     <= w_win ? q1 : q0;
                  r_mul_start <= 1'b1;
                  r_ack0      <= ~w_win;
                  r_ack1      <= w_win;
                  r_state     <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (mul_busy) begin
                  r_state <= S_RUN;
               end else begin
                  r_cnt <= w_cnt_nxt;
                  if (w_timeout) r_state <= S_DONE;
               end
            end
            S_RUN: begin
               if (!mul_busy) r_state <= S_DONE;
            end
            S_DONE: begin
               r_last_grant <= r_owner;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         // Result lands with the done pulse; a failed launch returns zero.
         if (w_finish) begin
            r_err <= w_timeout;
            if (r_owner) begin
               r_done1 <= 1'b1;
               r_m1    <= w_result;
            end else begin
               r_done0 <= 1'b1;
               r_m0    <= w_result;
            end
         end
      end
   end

   assign ack0      = r_ack0;
   assign ack1      = r_ack1;
   assign done0     = r_done0;
   assign done1     = r_done1;
   assign m0        = r_m0;
   assign m1        = r_m1;
   assign mul_start = r_mul_start;
   assign mul_p     = r_mul_p;
   assign mul_q     = r_mul_q;
   assign owner     = r_owner;
   assign err       = r_err;

endmodule

// File: tb/tb_arbitro_multiplicador.sv
// Bench for arbitro_multiplicador: table of directed operations plus timeout and mid-run reset sequences.
module tb_arbitro_multiplicador;

   localparam int BUSY_LEN = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [7:0]  p0 = '0, q0 = '0, p1 = '0, q1 = '0;
   logic        ack0, ack1, done0, done1, mul_start, owner, err;
   logic [15:0] m0, m1;
   logic [7:0]  mul_p, mul_q;
   logic        mul_busy;
   logic [15:0] mul_m;

   int n_chk = 0;
   int n_err = 0;
   logic [15:0] sh_m0 = '0, sh_m1 = '0;

   arbitro_multiplicador #(.WIDTH(8), .BUSY_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .p0(p0), .q0(q0), .ack0(ack0), .done0(done0), .m0(m0),
      .req1(req1), .p1(p1), .q1(q1), .ack1(ack1), .done1(done1), .m1(m1),
      .mul_start(mul_start), .mul_p(mul_p), .mul_q(mul_q),
      .mul_busy(mul_busy), .mul_m(mul_m), .owner(owner), .err(err)
   );

   always #5 clk = ~clk;

   // Multiplier model: busy for BUSY_LEN cycles after start; mdl_dead makes it ignore start.
   logic        mdl_busy = 1'b0;
   logic        mdl_dead = 1'b0;
   logic [15:0] mdl_m = '0;
   logic [7:0]  mdl_p = '0, mdl_q = '0;
   int          mdl_cnt = 0;

   always @(posedge clk) begin
      if (mdl_cnt != 0) begin
         if (mdl_cnt == 1) begin
            mdl_busy <= 1'b0;
            mdl_m    <= 16'(mdl_p) * 16'(mdl_q);
         end
         mdl_cnt <= mdl_cnt - 1;
      end else if (mul_start && !mdl_dead) begin
         mdl_p    <= mul_p;
         mdl_q    <= mul_q;
         mdl_busy <= 1'b1;
         mdl_cnt  <= BUSY_LEN;
      end
   end

   assign mul_busy = mdl_busy;
   assign mul_m    = mdl_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, " ctl"}, 32'({ack0, ack1, done0, done1, mul_start, err, owner}), 32'd0);
      chk({name, " mul_pq"}, 32'({mul_p, mul_q}), 32'd0);
      chk({name, " m0"}, 32'(m0), 32'd0);
      chk({name, " m1"}, 32'(m1), 32'd0);
   endtask

   task automatic do_op(input string tag,
                        input logic r0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic r1, input logic [7:0] a1, input logic [7:0] b1,
                        input logic chg, input logic eown, input logic [15:0] em,
                        input logic eerr, input int elat);
      logic [7:0] sp, sq;
      logic       stable;
      logic       seen;
      int         lat;
      req0 = r0; p0 = a0; q0 = b0;
      req1 = r1; p1 = a1; q1 = b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, " ack_seen"}, 32'(seen), 32'd1);
      if (!seen) return;
      chk({tag, " ack"}, 32'({ack1, ack0}), eown ? 32'd2 : 32'd1);
      chk({tag, " start"}, 32'(mul_start), 32'd1);
      chk({tag, " owner"}, 32'(owner), 32'(eown));
      chk({tag, " mul_p"}, 32'(mul_p), eown ? 32'(a1) : 32'(a0));
      chk({tag, " mul_q"}, 32'(mul_q), eown ? 32'(b1) : 32'(b0));
      sp = mul_p;
      sq = mul_q;
      stable = 1'b1;
      if (chg) p0 = 8'd99;
      seen = 1'b0;
      lat = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         lat++;
         if (mul_p !== sp || mul_q !== sq) stable = 1'b0;
         if (done0 || done1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      if (!seen) return;
      chk({tag, " latency"}, 32'(lat), 32'(elat));
      chk({tag, " done"}, 32'({done1, done0}), eown ? 32'd2 : 32'd1);
      chk({tag, " m_owner"}, eown ? 32'(m1) : 32'(m0), 32'(em));
      chk({tag, " err"}, 32'(err), 32'(eerr));
      chk({tag, " m_other"}, eown ? 32'(m0) : 32'(m1), eown ? 32'(sh_m0) : 32'(sh_m1));
      chk({tag, " pq_stable"}, 32'(stable), 32'd1);
      if (eown) sh_m1 = em;
      else      sh_m0 = em;
   endtask

   typedef struct {
      logic        r0;
      logic [7:0]  p0, q0;
      logic        r1;
      logic [7:0]  p1, q1;
      logic        chg;
      logic        eown;
      logic [15:0] em;
   } vec_t;

   vec_t tv[10];
   logic bad;

   initial begin
      tv[0] = '{1'b1, 8'd3,   8'd5,   1'b1, 8'd7,   8'd9,   1'b0, 1'b0, 16'd15};
      tv[1] = '{1'b1, 8'd3,   8'd5,   1'b1, 8'd7,   8'd9,   1'b0, 1'b1, 16'd63};
      tv[2] = '{1'b1, 8'd3,   8'd5,   1'b1, 8'd7,   8'd9,   1'b0, 1'b0, 16'd15};
      tv[3] = '{1'b1, 8'd3,   8'd5,   1'b1, 8'd7,   8'd9,   1'b0, 1'b1, 16'd63};
      tv[4] = '{1'b1, 8'd3,   8'd5,   1'b1, 8'd7,   8'd9,   1'b0, 1'b0, 16'd15};
      tv[5] = '{1'b1, 8'd3,   8'd5,   1'b1, 8'd7,   8'd9,   1'b0, 1'b1, 16'd63};
      tv[6] = '{1'b1, 8'd12,  8'd13,  1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 16'd156};
      tv[7] = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd255, 8'd255, 1'b0, 1'b1, 16'd65025};
      tv[8] = '{1'b1, 8'd0,   8'd200, 1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 16'd0};
      tv[9] = '{1'b1, 8'd11,  8'd7,   1'b0, 8'd0,   8'd0,   1'b1, 1'b0, 16'd77};

      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("idle_no_req start", 32'(mul_start), 32'd0);

      for (int i = 0; i < 10; i++) begin
         do_op($sformatf("v%0d", i), tv[i].r0, tv[i].p0, tv[i].q0,
               tv[i].r1, tv[i].p1, tv[i].q1, tv[i].chg, tv[i].eown, tv[i].em, 1'b0, 10);
      end
      req0 = 1'b0; req1 = 1'b0;

      // Launch timeout: the multiplier never raises busy.
      mdl_dead = 1'b1;
      do_op("tmo", 1'b1, 8'd5, 8'd6, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1, 5);
      req0 = 1'b0;
      @(negedge clk);
      chk("tmo err_pulse", 32'({err, done0}), 32'd0);
      mdl_dead = 1'b0;
      do_op("post_tmo", 1'b1, 8'd2, 8'd3, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 16'd6, 1'b0, 10);
      req0 = 1'b0;

      // Reset while the multiplier is running; the new grant must wait for busy low.
      req0 = 1'b1; p0 = 8'd10; q0 = 8'd10;
      bad = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ack0) begin
            bad = 1'b0;
            break;
         end
      end
      chk("rst_mid ack", 32'(bad), 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_mid busy_before", 32'(mul_busy), 32'd1);
      rst = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      sh_m0 = '0;
      sh_m1 = '0;
      p0 = 8'd4; q0 = 8'd4;
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!mul_busy) break;
         if (mul_start || ack0) bad = 1'b1;
      end
      chk("rst_mid hold_off", 32'(bad), 32'd0);
      chk("rst_mid busy_fell", 32'(mul_busy), 32'd0);
      do_op("rst_rec", 1'b1, 8'd4, 8'd4, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 16'd16, 1'b0, 10);
      req0 = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/arbitro_multiplicador.md
Name: arbitro_multiplicador

Overview:
Round-robin arbiter and sequencer that shares one shift-add 8x8 multiplier (start/busy/P/Q/M interface) between two requesters. It accepts operands from the winning requester and drives a one-cycle start pulse. It tracks the multiplier's busy handshake, captures the 16-bit product and returns it to the owner with a done pulse. A watchdog flags a multiplier that never asserts busy.

Parameters:
WIDTH, 8, operand width; product width is 2*WIDTH
BUSY_TIMEOUT, 4, max cycles in WAIT_BUSY before declaring a launch failure (range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 request; held high with stable p0/q0 until ack0
p0  input  WIDTH  requester 0 multiplicand
q0  input  WIDTH  requester 0 multiplier
ack0  output  1  one-cycle pulse: operands of requester 0 accepted
done0  output  1  one-cycle pulse: m0 valid
m0  output  2*WIDTH  product for requester 0; held until next done0
req1, p1, q1, ack1, done1, m1  same as requester 0, for requester 1
mul_start  output  1  start pulse to multiplier
mul_p  output  WIDTH  registered operand P to multiplier
mul_q  output  WIDTH  registered operand Q to multiplier
mul_busy  input  1  multiplier busy
mul_m  input  2*WIDTH  multiplier product, valid when busy falls
owner  output  1  index of current or last granted requester
err  output  1  one-cycle pulse on launch timeout

Behaviour:
- All outputs registered. Reset (async, any state) forces state IDLE and sets ack*, done*, mul_start, err, owner to 0. Reset clears mul_p, mul_q, m0, m1 to 0 and sets last_grant to 1, so requester 0 wins the first tie.
- States: IDLE, LAUNCH, WAIT_BUSY, RUN, DONE.
- IDLE: grant only if mul_busy==0 and at least one req is high.
  - Single req: that requester wins.
  - Both req: winner = !last_grant.
  - On grant: latch p/q into mul_p/mul_q, set owner, go to LAUNCH.
  - If mul_busy==1, stay in IDLE. This covers a multiplier still busy after an arbiter reset; it has no reset of its own.
- LAUNCH (exactly 1 cycle): mul_start=1 and ack_owner=1, same cycle. Clear timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - mul_busy==1 → RUN.
  - Otherwise increment counter. When counter reaches BUSY_TIMEOUT → DONE with the fail flag set.
- RUN: stay while mul_busy==1. On the first cycle mul_busy==0, capture mul_m into the result register and go to DONE.
- DONE (1 cycle):
  - done_owner=1; m_owner updates this same cycle to the captured product, or to 0 on failure. err=1 on failure only.
  - last_grant ← owner. Go to IDLE.
  - The m of the non-owner is untouched.
- Latency: ack at T+1 after the IDLE grant edge T. done at one cycle after RUN first samples busy low. Minimum turnaround between consecutive starts is 4 cycles plus multiplier busy time.
- Requesters: req sampled only in IDLE. A req still high after ack is a new request, arbitrated at the next IDLE. A req dropped before grant is ignored. Operand changes after ack have no effect (operands are latched).
- Starvation-free: with both requesters holding req, grants alternate 0,1,0,1…
- mul_p/mul_q stay stable from LAUNCH through DONE.
- Products are unsigned, full 2*WIDTH, no truncation.
- mul_busy glitches high in IDLE: no action. mul_busy high in DONE: ignored; the next grant waits for busy low.

Test Plan:
- Single request: req0=1, p0=12, q0=13 after reset → ack0 and mul_start one cycle each, same cycle; done0 pulse with m0=156; err=0; m1 stays 0.
- Simultaneous request: req0 (3×5) and req1 (7×9) asserted in the same cycle after reset → requester 0 served first (m0=15), then requester 1 (m1=63). Holding both req high for four more operations → order 0,1,0,1.
- Full-scale operands: req1, p1=255, q1=255 → m1=65025; p0=0, q0=200 → m0=0 with done0.
- Launch timeout: multiplier model holds mul_busy=0 → BUSY_TIMEOUT=4 cycles after WAIT_BUSY entry, one-cycle err and done0 pulses with m0=0; arbiter returns to IDLE and serves the next request normally.
- Reset mid-operation: assert rst during RUN → all outputs 0 immediately. With mul_busy still high, mul_start stays 0 while req0 is pending; the grant occurs only after mul_busy falls.
- Operand change after ack: change p0 to 99 on the cycle after ack0 → the result still uses the original operand.
